data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Word-addressed data memory consumed by the single-cycle CPU datapath: adr=ALUout, DataIn=busB, WrEn=MemWr,
//  RdEn=MemToReg, dout feeds the MemToReg mux. Replaces the read_0 stub.
//  Combinational read, synchronous write. A post-reset clear FSM zeroes the array before the CPU may access it.
//  Sticky error flags and a commit counter support debug and verification.
// PARAMETERS
//  DEPTH_LOG2  10            log2 of word count (DEPTH = 2**DEPTH_LOG2 words)
//  BASE_ADDR   32'h10010000  byte address of word 0; must be word aligned
// PORTS
//  clk          in   1   clock; all state updates on posedge
//  rst_n        in   1   synchronous, active-low reset
//  WrEn         in   1   store request this cycle
//  RdEn         in   1   load request this cycle; used only for error checking, dout is always driven
//  adr          in   32  byte address
//  DataIn       in   32  store data
//  dout         out  32  load data
//  busy         out  1   high while in reset or CLEAR; CPU must stall
//  misalign_err out  1   sticky: access with adr[1:0]!=0
//  range_err    out  1   sticky: access outside [BASE_ADDR, BASE_ADDR+4*DEPTH)
//  wr_drop      out  1   sticky: WrEn seen while busy
//  wr_count     out  32  number of committed writes, wraps 2^32-1 -> 0
// BEHAVIOUR
//  - Decode: off = adr - BASE_ADDR (32-bit, wraps); in_range = off < 4*DEPTH; aligned = adr[1:0]==0;
//    idx = off[DEPTH_LOG2+1:2].
//  - Reset (rst_n=0 at a posedge): state<=CLEAR, clr_cnt<=0, all sticky flags<=0, wr_count<=0.
//    While rst_n=0 the array is not written.
//  - Outputs while rst_n=0 or state==CLEAR: busy=1, dout=0.
//  - CLEAR state: each posedge writes 0 to mem[clr_cnt] and increments clr_cnt.
//    The posedge that writes index DEPTH-1 moves state to READY.
//    CLEAR lasts exactly DEPTH cycles after the first posedge with rst_n=1; busy falls in the following cycle.
//  - Any WrEn=1 while busy (reset or CLEAR): write ignored, wr_drop<=1 (unless rst_n=0 at that edge).
//    RdEn while busy: no flag.
//  - READY state, busy=0:
//    - dout = mem[idx] when in_range && aligned, else 32'h0. Pure combinational; no added latency.
//    - Write commits at posedge when WrEn && in_range && aligned: mem[idx]<=DataIn, wr_count<=wr_count+1.
//    - Posedge with (WrEn||RdEn) && !aligned: misalign_err<=1. No write occurs.
//    - Posedge with (WrEn||RdEn) && !in_range: range_err<=1. No write occurs.
//      Both flags set together when both conditions hold.
//  - Read-during-write, same address: dout shows the old word for the rest of the cycle; the new word is
//    visible from the next cycle.
//  - WrEn and RdEn both high: treated as a write; errors evaluated once.
//  - Reset asserted mid-operation (any state): takes priority at that edge; the write in that cycle is
//    discarded and the array is re-cleared from index 0.
//  - Sticky flags clear only on reset. No other state resets the array.
// TESTING
//  1 Reset then release: busy=1 for exactly 1024 cycles after rst_n rises, then 0; every readable word reads
//    0; all flags 0; wr_count=0.
//  2 Store adr=0x10010008 DataIn=0xDEADBEEF with WrEn. Same cycle: dout=0 (old data). Next cycle, RdEn at
//    same adr: dout=0xDEADBEEF, wr_count=1.
//  3 WrEn at adr=0x1001000A: no write (word 2 unchanged), misalign_err=1, wr_count unchanged.
//    adr=0x10011000 (one past top): range_err=1. adr=0x1000FFFC: range_err=1, dout=0.
//  4 WrEn held high during CLEAR: wr_drop=1, array still all zeros at READY, wr_count=0.
//  5 Write words 0 and 1023, assert rst_n=0 for 1 cycle mid-stream with WrEn=1: write discarded, flags and
//    wr_count=0, 1024-cycle CLEAR repeats, words 0 and 1023 read 0.
//  6 Back-to-back stores to all 1024 words with data=index, then read all back: exact match, wr_count=1024,
//    no flags set.

Source files
------------

// File: rtl/data_mem.sv
// Word-addressed data memory for the single-cycle CPU: combinational read, synchronous write,
// post-reset clear sequence, sticky access-error flags and a committed-write counter.
module data_mem #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        WrEn,
  input  logic        RdEn,
  input  logic [31:0] adr,
  input  logic [31:0] DataIn,
  output logic [31:0] dout,
  output logic        busy,
  output logic        misalign_err,
  output logic        range_err,
  output logic        wr_drop,
  output logic [31:0] wr_count
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned IW    = DEPTH_LOG2;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] clr_cnt_q, clr_cnt_d;
  logic          misalign_q, misalign_d;
  logic          range_q, range_d;
  logic          drop_q, drop_d;
  logic [31:0]   wr_count_q, wr_count_d;

  logic [31:0]   mem [DEPTH];

  logic [31:0]   off_c;
  logic          in_range_c;
  logic          aligned_c;
  logic [IW-1:0] idx_c;
  logic          access_c;
  logic          mem_we_c;
  logic [IW-1:0] mem_wa_c;
  logic [31:0]   mem_wd_c;

  // Address decode relative to the memory window
  assign off_c      = adr - BASE_ADDR;
  assign in_range_c = off_c < SPAN;
  assign aligned_c  = adr[1:0] == 2'b00;
  assign idx_c      = off_c[IW+1:2];
  assign access_c   = WrEn || RdEn;

  // Reset and the clear sweep both hold the CPU off the array
  assign busy = !rst_n || (state_q == ST_CLEAR);
  assign dout = (!busy && in_range_c && aligned_c) ? mem[idx_c] : 32'h0;

  assign misalign_err = misalign_q;
  assign range_err    = range_q;
  assign wr_drop      = drop_q;
  assign wr_count     = wr_count_q;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    misalign_d = misalign_q;
    range_d    = range_q;
    drop_d     = drop_q;
    wr_count_d = wr_count_q;
    mem_we_c   = 1'b0;
    mem_wa_c   = clr_cnt_q;
    mem_wd_c   = 32'h0;
    case (state_q)
      ST_CLEAR: begin
        mem_we_c  = 1'b1;
        clr_cnt_d = IW'(clr_cnt_q + 1'b1);
        if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
        if (WrEn) drop_d = 1'b1;
      end
      ST_READY: begin
        if (access_c && !aligned_c)  misalign_d = 1'b1;
        if (access_c && !in_range_c) range_d    = 1'b1;
        if (WrEn && in_range_c && aligned_c) begin
          mem_we_c   = 1'b1;
          mem_wa_c   = idx_c;
          mem_wd_c   = DataIn;
          wr_count_d = wr_count_q + 32'd1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      misalign_q <= 1'b0;
      range_q    <= 1'b0;
      drop_q     <= 1'b0;
      wr_count_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      misalign_q <= misalign_d;
      range_q    <= range_d;
      drop_q     <= drop_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Array has no reset of its own; the clear sweep zeroes it
  always_ff @(posedge clk) begin
    if (rst_n && mem_we_c) mem[mem_wa_c] <= mem_wd_c;
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: a reference model predicts dout per access into a
// scoreboard queue, and flags/counters are compared against the model after each phase.
module tb_data_mem;

  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WrEn, RdEn;
  logic [31:0] adr, DataIn;
  logic [31:0] dout;
  logic        busy, misalign_err, range_err, wr_drop;
  logic [31:0] wr_count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [31:0] exp_q [$];
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_cnt;
  logic        m_mis, m_rng, m_drop;

  data_mem dut (
    .clk(clk), .rst_n(rst_n), .WrEn(WrEn), .RdEn(RdEn), .adr(adr), .DataIn(DataIn),
    .dout(dout), .busy(busy), .misalign_err(misalign_err), .range_err(range_err),
    .wr_drop(wr_drop), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_misalign"}, 32'(misalign_err), 32'(m_mis));
    check({tag, "_range"}, 32'(range_err), 32'(m_rng));
    check({tag, "_wr_drop"}, 32'(wr_drop), 32'(m_drop));
    check({tag, "_wr_count"}, wr_count, m_cnt);
  endtask

  // One READY-state access: called at negedge, checks dout mid-cycle, returns at next negedge
  task automatic step(input string tag, input logic wr, input logic rd,
                      input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    logic        ok_rng, ok_al;
    int unsigned idx;
    off    = a - BASE;
    ok_rng = off < 32'(4 * DEPTH);
    ok_al  = (a[1:0] == 2'b00);
    idx    = int'(off[11:2]);
    WrEn = wr; RdEn = rd; adr = a; DataIn = d;
    exp_q.push_back((ok_rng && ok_al) ? m_mem[idx] : 32'h0);
    #2;
    check({tag, "_dout"}, dout, exp_q.pop_front());
    @(posedge clk);
    if ((wr || rd) && !ok_al)  m_mis = 1'b1;
    if ((wr || rd) && !ok_rng) m_rng = 1'b1;
    if (wr && ok_rng && ok_al) begin
      m_mem[idx] = d;
      m_cnt      = m_cnt + 32'd1;
    end
    @(negedge clk);
    WrEn = 1'b0; RdEn = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < int'(DEPTH); i++) step(tag, 1'b0, 1'b1, BASE + 32'(4 * i), 32'h0);
  endtask

  // Reset pulse at a negedge; optionally store during reset edge and hold WrEn through CLEAR
  task automatic do_reset(input string tag, input logic wr_in_rst, input logic hold_wr);
    int unsigned busy_cycles;
    rst_n = 1'b0; WrEn = wr_in_rst; adr = BASE + 32'd20; DataIn = 32'hBAD0_BAD0;
    #2;
    check({tag, "_busy_in_reset"}, 32'(busy), 32'd1);
    check({tag, "_dout_in_reset"}, dout, 32'h0);
    @(posedge clk);
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 32'h0;
    m_cnt = 32'h0; m_mis = 1'b0; m_rng = 1'b0; m_drop = hold_wr;
    @(negedge clk);
    rst_n = 1'b1; WrEn = hold_wr;
    busy_cycles = 0;
    while (busy && busy_cycles < 3000) begin
      busy_cycles++;
      @(negedge clk);
    end
    WrEn = 1'b0;
    check({tag, "_busy_cycles"}, busy_cycles, 32'd1024);
  endtask

  initial begin
    rst_n = 1'b0; WrEn = 1'b0; RdEn = 1'b0; adr = BASE; DataIn = 32'h0;
    m_cnt = 32'h0; m_mis = 1'b0; m_rng = 1'b0; m_drop = 1'b0;
    @(negedge clk);
    @(negedge clk);

    do_reset("t1", 1'b0, 1'b0);
    check_flags("t1");
    read_all("t1_rd");
    check_flags("t1_after_rd");

    step("t2_wr", 1'b1, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF);
    step("t2_rd", 1'b0, 1'b1, 32'h1001_0008, 32'h0);
    check("t2_wr_count", wr_count, 32'd1);

    step("t3_mis", 1'b1, 1'b0, 32'h1001_000A, 32'h1111_2222);
    check("t3_misalign", 32'(misalign_err), 32'd1);
    check("t3_range_clear", 32'(range_err), 32'd0);
    step("t3_w2", 1'b0, 1'b1, 32'h1001_0008, 32'h0);
    step("t3_top", 1'b1, 1'b0, 32'h1001_1000, 32'h3333_4444);
    check("t3_range_top", 32'(range_err), 32'd1);
    step("t3_below", 1'b0, 1'b1, 32'h1000_FFFC, 32'h0);
    step("t3_both", 1'b0, 1'b1, 32'h1001_1002, 32'h0);
    check_flags("t3");

    do_reset("t4", 1'b0, 1'b1);
    check_flags("t4");
    check("t4_wr_drop", 32'(wr_drop), 32'd1);
    read_all("t4_rd");

    step("t5_w0", 1'b1, 1'b0, BASE, 32'hAAAA_0000);
    step("t5_w1023", 1'b1, 1'b0, BASE + 32'hFFC, 32'hAAAA_03FF);
    step("t5_r1023", 1'b0, 1'b1, BASE + 32'hFFC, 32'h0);
    check("t5_cnt_pre", wr_count, 32'd2);
    do_reset("t5", 1'b1, 1'b0);
    check_flags("t5");
    step("t5_r0", 1'b0, 1'b1, BASE, 32'h0);
    step("t5_r1023b", 1'b0, 1'b1, BASE + 32'hFFC, 32'h0);
    step("t5_r5", 1'b0, 1'b1, BASE + 32'd20, 32'h0);

    for (int i = 0; i < int'(DEPTH); i++) step("t6_wr", 1'b1, 1'b0, BASE + 32'(4 * i), 32'(i));
    read_all("t6_rd");
    check("t6_wr_count", wr_count, 32'd1024);
    check_flags("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
